cpu_run_controller: RTL and testbench

- Synthesizable run-control block placed between the board-level clock/reset and a CPU core (single-cycle or later multi-cycle).
- Sequences the CPU reset: holds the core in reset for a parametrised number of cycles, releases it, then bounds the run by a halt request or a cycle budget.
- Reports cycle and retired-instruction counts, and the PC at halt, for bring-up and regression benches.

---
 rtl/cpu_run_controller.sv | 236 +++++++++++++++++++++++
 tb/tb_cpu_run_controller.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: sequences a CPU core through reset, run and done.
// The core is held in reset for RESET_CYCLES cycles after a start
// command, then runs until a halt request, a stall or the cycle
// budget ends the run. Cycle and retired-instruction counts and the PC
// at the end of the run are kept for bring-up benches.
//
// Optional feature: define CPU_RUN_STALL_DETECT_EN to end the run when
// the PC stays unchanged for STALL_LIMIT consecutive RUN cycles. With
// the macro undefined, the stall logic is absent and stalled reads 0.
//
// Command interface: start and abort are single-cycle commands sampled
// on the rising clock edge. There is no ready signal. A start outside
// IDLE or DONE is dropped. An abort is always taken and wins over a
// start in the same cycle.

module cpu_run_controller #(
    parameter int ADDR_W       = 32,
    parameter int CNT_W        = 32,
    parameter int RESET_CYCLES = 3,
    parameter int MAX_CYCLES   = 1000,
    parameter int STALL_LIMIT  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              halt_req,
    input  logic              instr_valid,
    input  logic [ADDR_W-1:0] pc,
    output logic              cpu_rst_n,
    output logic              running,
    output logic              done,
    output logic              timeout,
    output logic              stalled,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  instr_count,
    output logic [ADDR_W-1:0] halt_pc
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_RESET_HOLD = 2'd1,
        S_RUN        = 2'd2,
        S_DONE       = 2'd3
    } state_t;

    localparam int               HOLD_W     = $clog2(RESET_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_SAT   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  BUDGET_AT = CNT_W'(MAX_CYCLES - 1);

    // Reject parameter values the sequencing cannot honour.
    if (RESET_CYCLES < 1 || MAX_CYCLES < 1 || STALL_LIMIT < 1) begin : g_param_check
        $error("cpu_run_controller: RESET_CYCLES, MAX_CYCLES and STALL_LIMIT must be >= 1");
    end

    state_t            state_q;
    state_t            state_d;
    logic [HOLD_W-1:0] hold_cnt;
    logic              go_hold;
    logic              exit_halt;
    logic              exit_stall;
    logic              exit_timeout;
    logic              stall_hit;
    logic              budget_hit;
    logic              run_d;
    logic              done_d;

    // The budget ends on the edge where the count reaches MAX_CYCLES.
    assign budget_hit = (cycle_count == BUDGET_AT);

    // State register plus the registered run/done/core-reset outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            running   <= 1'b0;
            done      <= 1'b0;
            cpu_rst_n <= 1'b0;
        end else begin
            state_q   <= state_d;
            running   <= run_d;
            done      <= done_d;
            cpu_rst_n <= run_d;
        end
    end

    // Next-state decode with RUN exit priority abort > halt > stall > budget.
    always_comb begin
        state_d      = state_q;
        go_hold      = 1'b0;
        exit_halt    = 1'b0;
        exit_stall   = 1'b0;
        exit_timeout = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!abort && start) begin
                    state_d = S_RESET_HOLD;
                    go_hold = 1'b1;
                end
            end
            S_RESET_HOLD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (halt_req) begin
                    state_d   = S_DONE;
                    exit_halt = 1'b1;
                end else if (stall_hit) begin
                    state_d    = S_DONE;
                    exit_stall = 1'b1;
                end else if (budget_hit) begin
                    state_d      = S_DONE;
                    exit_timeout = 1'b1;
                end
            end
            S_DONE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d = S_RESET_HOLD;
                    go_hold = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: flags for the state being entered on the next edge.
    always_comb begin
        run_d  = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // Reset-hold counter: counts RESET_HOLD cycles, zero everywhere else.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
        end else if (state_q == S_RESET_HOLD && state_d == S_RESET_HOLD) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end else begin
            hold_cnt <= '0;
        end
    end

    // Run counters: cleared on start, saturating increments on every RUN
    // cycle including the one whose edge ends the run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else if (go_hold) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else if (state_q == S_RUN) begin
            if (cycle_count != CNT_SAT) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
            if (instr_valid && instr_count != CNT_SAT) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    // Run results: PC and timeout flag captured when the run ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halt_pc <= '0;
            timeout <= 1'b0;
        end else if (go_hold) begin
            halt_pc <= '0;
            timeout <= 1'b0;
        end else begin
            if (exit_halt || exit_stall || exit_timeout) begin
                halt_pc <= pc;
            end
            if (exit_timeout) begin
                timeout <= 1'b1;
            end
        end
    end

`ifdef CPU_RUN_STALL_DETECT_EN
    localparam int               STALL_W    = $clog2(STALL_LIMIT + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);

    logic [ADDR_W-1:0]  prev_pc;
    logic               pc_seen;
    logic               pc_repeat;
    logic [STALL_W-1:0] stall_cnt;
    logic               stalled_q;

    // The first RUN cycle has no previous PC, so it always counts as a change.
    assign pc_repeat = pc_seen && (pc == prev_pc);
    assign stall_hit = (state_q == S_RUN) && pc_repeat && (stall_cnt == STALL_LAST);
    assign stalled   = stalled_q;

    // Stall tracking: counts consecutive RUN cycles with an unchanged PC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_pc   <= '0;
            pc_seen   <= 1'b0;
            stall_cnt <= '0;
        end else if (state_q == S_RUN) begin
            prev_pc   <= pc;
            pc_seen   <= 1'b1;
            stall_cnt <= pc_repeat ? stall_cnt + STALL_W'(1) : '0;
        end else begin
            pc_seen   <= 1'b0;
            stall_cnt <= '0;
        end
    end

    // Stall result flag: set when a stall ends the run, cleared on start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stalled_q <= 1'b0;
        end else if (go_hold) begin
            stalled_q <= 1'b0;
        end else if (exit_stall) begin
            stalled_q <= 1'b1;
        end
    end
`else
    assign stall_hit = 1'b0;
    assign stalled   = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller: directed bench for cpu_run_controller with
// RESET_CYCLES=3, MAX_CYCLES=20, STALL_LIMIT=4. Expected run results
// are queued when a run is launched and compared when done rises.

module tb_cpu_run_controller;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;
  localparam int RW     = 2 + 2 * CNT_W + ADDR_W;

  logic              clk;
  logic              rst;
  logic              start;
  logic              abort;
  logic              halt_req;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;
  logic              cpu_rst_n;
  logic              running;
  logic              done;
  logic              timeout;
  logic              stalled;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  instr_count;
  logic [ADDR_W-1:0] halt_pc;

  logic [RW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  cpu_run_controller #(
    .ADDR_W       (ADDR_W),
    .CNT_W        (CNT_W),
    .RESET_CYCLES (3),
    .MAX_CYCLES   (20),
    .STALL_LIMIT  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .halt_req    (halt_req),
    .instr_valid (instr_valid),
    .pc          (pc),
    .cpu_rst_n   (cpu_rst_n),
    .running     (running),
    .done        (done),
    .timeout     (timeout),
    .stalled     (stalled),
    .cycle_count (cycle_count),
    .instr_count (instr_count),
    .halt_pc     (halt_pc)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] result_vec();
    return {timeout, stalled, cycle_count, instr_count, halt_pc};
  endfunction

  function automatic logic [2:0] ctrl_vec();
    return {cpu_rst_n, running, done};
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // pop the expected result for the run that just ended and compare
  task automatic check_result(input string tag);
    logic [RW-1:0] exp;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed empty queue expected an entry", tag);
    end else begin
      exp = exp_q.pop_front();
      check(tag, 96'(result_vec()), 96'(exp));
    end
  endtask

  // bounded wait for done; an expired budget fails the done_seen check
  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    check(tag, 96'(done), 96'(1'b1));
  endtask

  // start pulse, then the reset hold with halt/instr driven (ignored there)
  task automatic enter_run();
    start = 1'b1;
    tick();
    start       = 1'b0;
    halt_req    = 1'b1;
    instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    halt_req    = 1'b0;
    instr_valid = 1'b0;
  endtask

  // directed sequence
  initial begin
    logic ivp [20];
    int   exp_i;

    rst = 1'b0; start = 1'b0; abort = 1'b0;
    halt_req = 1'b0; instr_valid = 1'b0; pc = '0;
    tick();
    tick();
    check("reset_ctrl", 96'(ctrl_vec()), 96'(3'b000));
    check("reset_result", 96'(result_vec()), 96'(0));

    // start while rst is still low at the edge is ignored
    start = 1'b1;
    tick();
    rst   = 1'b1;
    start = 1'b0;
    tick();
    check("start_in_reset_ignored", 96'(ctrl_vec()), 96'(3'b000));

    // reset hold length, then halt after 10 instructions
    start = 1'b1;
    pc    = 32'h100;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("hold_low", 96'({cpu_rst_n, running}), 96'(2'b00));
      tick();
    end
    check("run_entry", 96'(ctrl_vec()), 96'(3'b110));
    exp_q.push_back({1'b0, 1'b0, 16'd11, 16'd10, 32'h40});
    for (int i = 0; i < 10; i++) begin
      instr_valid = 1'b1;
      pc = 32'(32'h100 + 4 * i);
      tick();
    end
    instr_valid = 1'b0;
    halt_req    = 1'b1;
    pc          = 32'h40;
    tick();
    halt_req = 1'b0;
    check("halt_ctrl", 96'(ctrl_vec()), 96'(3'b001));
    check_result("halt_result");

    // budget exhaustion with random retirement
    enter_run();
    check("rerun_ctrl", 96'(ctrl_vec()), 96'(3'b110));
    check("rerun_cleared", 96'(result_vec()), 96'(0));
    exp_i = 0;
    for (int k = 0; k < 20; k++) begin
      ivp[k] = 1'($urandom_range(0, 1));
      exp_i += int'(ivp[k]);
    end
    exp_q.push_back({1'b1, 1'b0, 16'd20, exp_i[15:0], 32'(32'h200 + 4 * 19)});
    for (int k = 0; k < 20; k++) begin
      if (k == 19) check("no_done_before_budget", 96'(done), 96'(1'b0));
      instr_valid = ivp[k];
      pc = 32'(32'h200 + 4 * k);
      tick();
    end
    instr_valid = 1'b0;
    wait_done("timeout_done_seen", 3);
    check("timeout_ctrl", 96'(ctrl_vec()), 96'(3'b001));
    check_result("timeout_result");

    // halt on the budget-exhausting cycle wins over timeout
    enter_run();
    exp_q.push_back({1'b0, 1'b0, 16'd20, 16'd20, 32'(32'h300 + 4 * 19)});
    for (int k = 0; k < 20; k++) begin
      instr_valid = 1'b1;
      halt_req = (k == 19);
      pc = 32'(32'h300 + 4 * k);
      tick();
    end
    halt_req    = 1'b0;
    instr_valid = 1'b0;
    wait_done("halt20_done_seen", 3);
    check_result("halt20_result");

    // PC held constant
    enter_run();
    pc          = 32'h1C;
    instr_valid = 1'b1;
`ifdef CPU_RUN_STALL_DETECT_EN
    exp_q.push_back({1'b0, 1'b1, 16'd5, 16'd5, 32'h1C});
`else
    exp_q.push_back({1'b1, 1'b0, 16'd20, 16'd20, 32'h1C});
`endif
    wait_done("stall_done_seen", 40);
    instr_valid = 1'b0;
    check_result("stall_result");

    // abort together with start, 5 cycles into RUN
    enter_run();
    instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc = 32'(32'h500 + 4 * i);
      tick();
    end
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort_ctrl", 96'(ctrl_vec()), 96'(3'b000));
    check("abort_counts", 96'({cycle_count, instr_count}), 96'({16'd5, 16'd5}));
    halt_req = 1'b1;
    tick();
    tick();
    halt_req    = 1'b0;
    instr_valid = 1'b0;
    check("idle_counts_hold", 96'({ctrl_vec(), cycle_count, instr_count}), 96'({3'b000, 16'd5, 16'd5}));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_cleared", 96'(result_vec()), 96'(0));
    tick();
    tick();
    tick();
    check("restart_running", 96'(ctrl_vec()), 96'(3'b110));

    // asynchronous reset in the middle of a run
    instr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pc = 32'(32'h600 + 4 * i);
      tick();
    end
    check("pre_rst_count", 96'(cycle_count), 96'(16'd6));
    rst = 1'b0;
    #1;
    check("async_rst_ctrl", 96'(ctrl_vec()), 96'(3'b000));
    check("async_rst_result", 96'(result_vec()), 96'(0));
    tick();
    rst      = 1'b1;
    halt_req = 1'b1;
    tick();
    tick();
    tick();
    halt_req    = 1'b0;
    instr_valid = 1'b0;
    check("post_rst_idle", 96'({ctrl_vec(), result_vec()}), 96'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
